qtz_level_seg_buffer: RTL and testbench

//  Parametrised, double-buffered successor of the quantiser output register.

---
 rtl/qtz_level_seg_buffer.sv | 127 ++++++++++++
 tb/tb_qtz_level_seg_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/qtz_level_seg_buffer.sv
// Ping-pong level-HV bundle buffer: assembles NUM_SEG in-order segment beats into one
// FEATURES_PER_CC-entry bundle and presents completed bundles over valid/ready.
module qtz_level_seg_buffer #(
  parameter int unsigned HV_DIM          = 512,
  parameter int unsigned FEATURES_PER_CC = 118,
  parameter int unsigned NUM_SEG         = 2,
  localparam int unsigned SEG_FEAT       = FEATURES_PER_CC / NUM_SEG,
  localparam int unsigned SEGW           = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEGW-1:0]   in_seg,
  input  logic [HV_DIM-1:0] im_fetch_outputs [FEATURES_PER_CC],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] level_hvs [FEATURES_PER_CC],
  output logic              seg_err,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull} bank_st_e;

  bank_st_e          bank_st_q [2];
  bank_st_e          bank_st_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [SEGW-1:0]   seg_cnt_q, seg_cnt_d;
  logic              seg_err_q;
  logic [HV_DIM-1:0] bank_q [2][FEATURES_PER_CC];

  logic accept, seg_ok, wr_en, bad_beat, seg_last, drain;
  logic unused_fetch;

  assign in_ready  = (bank_st_q[wr_ptr_q] != BkFull);
  assign out_valid = (bank_st_q[rd_ptr_q] == BkFull);
  assign seg_err   = seg_err_q;
  assign occupancy = {1'b0, bank_st_q[0] == BkFull} + {1'b0, bank_st_q[1] == BkFull};

  // clr overrides any same-cycle beat or drain
  assign accept   = in_valid && in_ready && !clr;
  assign seg_ok   = (NUM_SEG == 1) || (in_seg == seg_cnt_q);
  assign wr_en    = accept && seg_ok;
  assign bad_beat = accept && !seg_ok;
  assign seg_last = (seg_cnt_q == SEGW'(NUM_SEG - 1));
  assign drain    = out_valid && out_ready && !clr;

  always_comb begin
    for (int unsigned f = 0; f < FEATURES_PER_CC; f++) begin
      level_hvs[f] = bank_q[rd_ptr_q][f];
    end
  end

  // Only entries [0:SEG_FEAT-1] carry beat data
  always_comb begin
    unused_fetch = 1'b0;
    for (int unsigned f = SEG_FEAT; f < FEATURES_PER_CC; f++) begin
      unused_fetch = unused_fetch ^ (^im_fetch_outputs[f]);
    end
  end

  always_comb begin
    bank_st_d = bank_st_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    seg_cnt_d = seg_cnt_q;
    if (clr) begin
      bank_st_d[0] = BkEmpty;
      bank_st_d[1] = BkEmpty;
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      seg_cnt_d    = '0;
    end else begin
      // Drain and write never target the same bank: one must be FULL, the other not
      if (drain) begin
        bank_st_d[rd_ptr_q] = BkEmpty;
        rd_ptr_d            = ~rd_ptr_q;
      end
      if (wr_en) begin
        if (seg_last) begin
          bank_st_d[wr_ptr_q] = BkFull;
          wr_ptr_d            = ~wr_ptr_q;
          seg_cnt_d           = '0;
        end else begin
          bank_st_d[wr_ptr_q] = BkFilling;
          seg_cnt_d           = seg_cnt_q + SEGW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bank_st_q[0] <= BkEmpty;
      bank_st_q[1] <= BkEmpty;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      seg_cnt_q    <= '0;
      seg_err_q    <= 1'b0;
    end else begin
      bank_st_q <= bank_st_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      seg_cnt_q <= seg_cnt_d;
      seg_err_q <= bad_beat;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned f = 0; f < FEATURES_PER_CC; f++) begin
          bank_q[b][f] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int unsigned f = 0; f < FEATURES_PER_CC; f++) begin
        if (f / SEG_FEAT == 32'(seg_cnt_q)) begin
          bank_q[wr_ptr_q][f] <= im_fetch_outputs[f % SEG_FEAT];
        end
      end
    end
  end

endmodule

// File: tb/tb_qtz_level_seg_buffer.sv
// Directed self-checking bench for qtz_level_seg_buffer with default parameters.
module tb_qtz_level_seg_buffer;

  localparam int unsigned HV_DIM   = 512;
  localparam int unsigned FEAT     = 118;
  localparam int unsigned NUM_SEG  = 2;
  localparam int unsigned SEG_FEAT = FEAT / NUM_SEG;
  localparam int unsigned SEGW     = 1;

  logic              clk = 1'b0;
  logic              nrst;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [SEGW-1:0]   in_seg;
  logic [HV_DIM-1:0] im_fetch_outputs [FEAT];
  logic              out_valid;
  logic              out_ready;
  logic [HV_DIM-1:0] level_hvs [FEAT];
  logic              seg_err;
  logic [1:0]        occupancy;

  int n_cmp = 0;
  int n_err = 0;

  qtz_level_seg_buffer #(
    .HV_DIM          (HV_DIM),
    .FEATURES_PER_CC (FEAT),
    .NUM_SEG         (NUM_SEG)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .clr              (clr),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_seg           (in_seg),
    .im_fetch_outputs (im_fetch_outputs),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .level_hvs        (level_hvs),
    .seg_err          (seg_err),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  // Entries differing from the expected bundle: lo fills [0:SEG_FEAT-1], hi the rest
  function automatic int count_bad(input logic [HV_DIM-1:0] lo, input logic [HV_DIM-1:0] hi);
    int bad = 0;
    for (int f = 0; f < FEAT; f++) begin
      if (level_hvs[f] !== ((f < SEG_FEAT) ? lo : hi)) bad++;
    end
    return bad;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [HV_DIM-1:0] val);
    for (int f = 0; f < FEAT; f++) im_fetch_outputs[f] = val;
  endtask

  // Offers one beat until accepted (bounded); returns #1 after the accepting edge
  task automatic send_beat(input logic [SEGW-1:0] seg, input logic [HV_DIM-1:0] val);
    logic took = 1'b0;
    int   budget = 0;
    in_valid = 1'b1;
    in_seg   = seg;
    set_data(val);
    while (!took && budget < 20) begin
      took = in_ready;
      step();
      budget++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!took) begin
      n_err++;
      $display("FAIL beat_accept_timeout: accepted=%0b required=1", took);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_seg = '0; out_ready = 1'b0;
    set_data('0);
    #1 nrst = 1'b0;
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (seg_err !== 1'b0) begin n_err++; $display("FAIL rst_seg_err: got %0b want 0", seg_err); end
    n_cmp++; if (count_bad('0, '0) != 0) begin n_err++; $display("FAIL rst_level_hvs: %0d bad entries want 0", count_bad('0, '0)); end
    nrst = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_basic_bundle();
    out_ready = 1'b1;
    send_beat(1'b0, 'hA5);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_half_valid: got %0b want 0", out_valid); end
    send_beat(1'b1, 'h3C);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %0b want 1", out_valid); end
    n_cmp++; if (count_bad('hA5, 'h3C) != 0) begin n_err++; $display("FAIL basic_data: %0d bad entries want 0", count_bad('hA5, 'h3C)); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL basic_occ: got %0d want 1", occupancy); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %0b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL basic_occ_drain: got %0d want 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send_beat(1'b0, 'h10); send_beat(1'b1, 'h11);
    send_beat(1'b0, 'h20); send_beat(1'b1, 'h21);
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL full_occ: got %0d want 2", occupancy); end
    in_valid = 1'b1; in_seg = 1'b0; set_data('h30);
    step(); step(); step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_stall: in_ready=%0b want 0", in_ready); end
    n_cmp++; if (count_bad('h10, 'h11) != 0) begin n_err++; $display("FAIL full_hold_b0: %0d bad entries want 0", count_bad('h10, 'h11)); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (count_bad('h20, 'h21) != 0 || out_valid !== 1'b1) begin n_err++; $display("FAIL drain_b1: bad=%0d valid=%0b want 0/1", count_bad('h20, 'h21), out_valid); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL drain_occ1: got %0d want 1", occupancy); end
    step();
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_b1_done: occ=%0d valid=%0b want 0/0", occupancy, out_valid); end
    in_seg = 1'b1; set_data('h31);
    step();
    in_valid = 1'b0;
    n_cmp++; if (count_bad('h30, 'h31) != 0 || out_valid !== 1'b1) begin n_err++; $display("FAIL drain_b2: bad=%0d valid=%0b want 0/1", count_bad('h30, 'h31), out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_b2_done: got %0b want 0", out_valid); end
  endtask

  task automatic test_seg_err();
    out_ready = 1'b0;
    send_beat(1'b1, 'hEE);
    n_cmp++; if (seg_err !== 1'b1) begin n_err++; $display("FAIL seg_err_pulse: got %0b want 1", seg_err); end
    // bank 0 is both write and read bank here and still holds the stale B1 bundle
    n_cmp++; if (count_bad('h20, 'h21) != 0) begin n_err++; $display("FAIL seg_err_untouched: %0d bad entries want 0", count_bad('h20, 'h21)); end
    step();
    n_cmp++; if (seg_err !== 1'b0) begin n_err++; $display("FAIL seg_err_width: got %0b want 0", seg_err); end
    send_beat(1'b0, 'h40);
    n_cmp++; if (seg_err !== 1'b0) begin n_err++; $display("FAIL seg_err_false: got %0b want 0", seg_err); end
    send_beat(1'b1, 'h41);
    n_cmp++; if (count_bad('h40, 'h41) != 0 || out_valid !== 1'b1) begin n_err++; $display("FAIL seg_err_recover: bad=%0d valid=%0b want 0/1", count_bad('h40, 'h41), out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_simul_complete_drain();
    out_ready = 1'b0;
    send_beat(1'b0, 'h50); send_beat(1'b1, 'h51);
    send_beat(1'b0, 'h60);
    n_cmp++; if (occupancy !== 2'd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL simul_pre: occ=%0d valid=%0b want 1/1", occupancy, out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; in_seg = 1'b1; set_data('h61);
    step();
    in_valid = 1'b0;
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL simul_occ: got %0d want 1", occupancy); end
    n_cmp++; if (out_valid !== 1'b1 || count_bad('h60, 'h61) != 0) begin n_err++; $display("FAIL simul_next: valid=%0b bad=%0d want 1/0", out_valid, count_bad('h60, 'h61)); end
    step();
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL simul_done: got %0d want 0", occupancy); end
    out_ready = 1'b0;
  endtask

  task automatic test_clr();
    send_beat(1'b0, 'h70); send_beat(1'b1, 'h71);
    send_beat(1'b0, 'h72);
    clr = 1'b1; in_valid = 1'b1; in_seg = 1'b1; set_data('h73); out_ready = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL clr_flush: valid=%0b occ=%0d want 0/0", out_valid, occupancy); end
    n_cmp++; if (in_ready !== 1'b1 || seg_err !== 1'b0) begin n_err++; $display("FAIL clr_ready: rdy=%0b err=%0b want 1/0", in_ready, seg_err); end
    send_beat(1'b0, 'h80);
    n_cmp++; if (seg_err !== 1'b0) begin n_err++; $display("FAIL clr_seg0: seg_err=%0b want 0", seg_err); end
    send_beat(1'b1, 'h81);
    n_cmp++; if (out_valid !== 1'b1 || count_bad('h80, 'h81) != 0) begin n_err++; $display("FAIL clr_after: valid=%0b bad=%0d want 1/0", out_valid, count_bad('h80, 'h81)); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_beat(1'b0, 'h90);
    nrst = 1'b0;
    #1;
    n_cmp++; if (count_bad('0, '0) != 0 || out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL rst_mid: bad=%0d valid=%0b occ=%0d want 0/0/0", count_bad('0, '0), out_valid, occupancy); end
    #2 nrst = 1'b1;
    step();
    send_beat(1'b0, 'hA0);
    n_cmp++; if (seg_err !== 1'b0) begin n_err++; $display("FAIL rst_mid_seg0: seg_err=%0b want 0", seg_err); end
    send_beat(1'b1, 'hA1);
    n_cmp++; if (out_valid !== 1'b1 || count_bad('hA0, 'hA1) != 0) begin n_err++; $display("FAIL rst_mid_bundle: valid=%0b bad=%0d want 1/0", out_valid, count_bad('hA0, 'hA1)); end
  endtask

  initial begin
    test_reset();
    test_basic_bundle();
    test_back_to_back();
    test_seg_err();
    test_simul_complete_drain();
    test_clr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
